// File: rtl/exec_ctrl.sv
// exec_ctrl: fetch/execute sequencer owning pc, gas, stack height, instruction count and halt status
module exec_ctrl #(
  parameter int PC_W = 16,
  parameter int GAS_W = 32,
  parameter int DEPTH = 1024,
  localparam int HEIGHT_W = $clog2(DEPTH+1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [GAS_W-1:0]    gas_limit,
  input  logic [PC_W-1:0]     code_size,
  output logic                code_req,
  output logic [PC_W-1:0]     code_addr,
  input  logic                code_vld,
  input  logic [7:0]          code_opcode,
  output logic                op_vld,
  output logic [7:0]          op_code,
  input  logic                op_rdy,
  input  logic [4:0]          op_pop,
  input  logic [4:0]          op_push,
  input  logic [GAS_W-1:0]    op_gas,
  input  logic [5:0]          op_len,
  input  logic                op_jump,
  input  logic                op_jump_ok,
  input  logic [PC_W-1:0]     op_jump_dest,
  input  logic                op_halt,
  output logic [PC_W-1:0]     pc,
  output logic [GAS_W-1:0]    gas_used,
  output logic [HEIGHT_W-1:0] height,
  output logic [31:0]         instr_cnt,
  output logic                busy,
  output logic                done,
  output logic [2:0]          status
);
  localparam int HX = HEIGHT_W + 6;
  localparam logic [2:0] ST_RUN = 3'd0, ST_STOP = 3'd1, ST_OOG = 3'd2, ST_UNDER = 3'd3,
                         ST_OVER = 3'd4, ST_BADJ = 3'd5, ST_ABORT = 3'd6;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, size_q, size_d;
  logic [GAS_W-1:0] gas_q, gas_d, limit_q, limit_d;
  logic [HEIGHT_W-1:0] height_q, height_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0] status_q, status_d;
  logic [7:0] opcode_q, opcode_d;
  logic [HX-1:0] h_new;
  logic [GAS_W:0] g_sum;
  logic [PC_W:0] pc_sum;
  assign h_new = HX'(height_q) + HX'(op_push) - HX'(op_pop);
  assign g_sum = {1'b0, gas_q} + {1'b0, op_gas};
  assign pc_sum = {1'b0, pc_q} + (PC_W+1)'(op_len);
  assign code_req = state_q == FETCH && pc_q < size_q;
  assign code_addr = pc_q;
  assign op_vld = state_q == EXEC;
  assign op_code = opcode_q;
  assign pc = pc_q;
  assign gas_used = gas_q;
  assign height = height_q;
  assign instr_cnt = cnt_q;
  assign busy = state_q == FETCH || state_q == EXEC;
  assign done = state_q == DONE;
  assign status = status_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    size_d = size_q;
    gas_d = gas_q;
    limit_d = limit_q;
    height_d = height_q;
    cnt_d = cnt_q;
    status_d = status_q;
    opcode_d = opcode_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = FETCH;
        pc_d = '0;
        gas_d = '0;
        height_d = '0;
        cnt_d = '0;
        status_d = ST_RUN;
        limit_d = gas_limit;
        size_d = code_size;
      end
      FETCH: if (abort) begin
        state_d = DONE;
        status_d = ST_ABORT;
      end else if (pc_q >= size_q) begin
        state_d = DONE;
        status_d = ST_STOP;
      end else if (code_vld) begin
        state_d = EXEC;
        opcode_d = code_opcode;
      end
      EXEC: if (abort) begin
        state_d = DONE;
        status_d = ST_ABORT;
      end else if (op_rdy) begin
        state_d = DONE;
        if (HX'(op_pop) > HX'(height_q)) status_d = ST_UNDER;
        else if (h_new > HX'(DEPTH)) status_d = ST_OVER;
        else if (g_sum > {1'b0, limit_q}) begin
          status_d = ST_OOG;
          gas_d = limit_q;
        end else if (op_jump && (!op_jump_ok || op_jump_dest >= size_q)) status_d = ST_BADJ;
        else begin
          gas_d = g_sum[GAS_W-1:0];
          height_d = h_new[HEIGHT_W-1:0];
          cnt_d = cnt_q + 32'd1;
          if (op_halt) status_d = ST_STOP;
          else if (op_jump) begin
            pc_d = op_jump_dest;
            state_d = FETCH;
          end else if (pc_sum[PC_W]) begin
            pc_d = '1;
            status_d = ST_STOP;
          end else begin
            pc_d = pc_sum[PC_W-1:0];
            state_d = FETCH;
          end
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= '0;
      size_q <= '0;
      gas_q <= '0;
      limit_q <= '0;
      height_q <= '0;
      cnt_q <= '0;
      status_q <= ST_RUN;
      opcode_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      size_q <= size_d;
      gas_q <= gas_d;
      limit_q <= limit_d;
      height_q <= height_d;
      cnt_q <= cnt_d;
      status_q <= status_d;
      opcode_q <= opcode_d;
    end
  end
endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: directed and random programs checked against a behavioural interpreter model
module tb_exec_ctrl;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, start = 0, abort = 0;
  logic [31:0] gas_limit = 0;
  logic [15:0] code_size = 0;
  logic code_req, code_vld = 0, op_vld, op_rdy = 0, op_jump = 0, op_jump_ok = 0, op_halt = 0;
  logic [15:0] code_addr, op_jump_dest = 0, pc;
  logic [7:0] code_opcode = 0, op_code;
  logic [4:0] op_pop = 0, op_push = 0;
  logic [31:0] op_gas = 0, gas_used, instr_cnt;
  logic [5:0] op_len = 1;
  logic [2:0] height;
  logic busy, done;
  logic [2:0] status;
  int errors = 0, checks = 0, cyc;
  int t_pop[64], t_push[64], t_gas[64], t_len[64], t_jmp[64], t_ok[64], t_dst[64], t_halt[64];
  logic [7:0] t_opc[64];
  exec_ctrl #(.PC_W(16), .GAS_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .gas_limit(gas_limit), .code_size(code_size),
    .code_req(code_req), .code_addr(code_addr), .code_vld(code_vld), .code_opcode(code_opcode),
    .op_vld(op_vld), .op_code(op_code), .op_rdy(op_rdy), .op_pop(op_pop), .op_push(op_push),
    .op_gas(op_gas), .op_len(op_len), .op_jump(op_jump), .op_jump_ok(op_jump_ok),
    .op_jump_dest(op_jump_dest), .op_halt(op_halt), .pc(pc), .gas_used(gas_used), .height(height),
    .instr_cnt(instr_cnt), .busy(busy), .done(done), .status(status));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clr_prog();
    for (int i = 0; i < 64; i++) begin
      t_pop[i] = 0; t_push[i] = 0; t_gas[i] = 0; t_len[i] = 1;
      t_jmp[i] = 0; t_ok[i] = 0; t_dst[i] = 0; t_halt[i] = 0; t_opc[i] = 8'($urandom);
    end
  endtask
  task automatic drive_op(input int i);
    op_pop = 5'(t_pop[i]); op_push = 5'(t_push[i]); op_gas = 32'(t_gas[i]); op_len = 6'(t_len[i]);
    op_jump = t_jmp[i][0]; op_jump_ok = t_ok[i][0]; op_jump_dest = 16'(t_dst[i]); op_halt = t_halt[i][0];
  endtask
  task automatic model(input int abort_n, output int st, output longint mpc, output longint gas,
                       output int h, output int n);
    int k, i;
    mpc = 0; gas = 0; h = 0; n = 0; k = 0; st = 0;
    while (st == 0) begin
      if (mpc >= code_size) st = 1;
      else begin
        i = int'(mpc) & 63;
        k++;
        if (k == abort_n) st = 6;
        else if (t_pop[i] > h) st = 3;
        else if (h - t_pop[i] + t_push[i] > DEPTH) st = 4;
        else if (gas + t_gas[i] > longint'(gas_limit)) begin st = 2; gas = gas_limit; end
        else if (t_jmp[i] != 0 && (t_ok[i] == 0 || t_dst[i] >= code_size)) st = 5;
        else begin
          gas += t_gas[i]; h += t_push[i] - t_pop[i]; n++;
          if (t_halt[i] != 0) st = 1;
          else if (t_jmp[i] != 0) mpc = t_dst[i];
          else if (mpc + t_len[i] > 65535) begin mpc = 65535; st = 1; end
          else mpc += t_len[i];
        end
      end
    end
  endtask
  task automatic run(input int fl, input int fh, input int el, input int eh, input int abort_n,
                     input bit sa, output int c);
    int fw, ew, k;
    logic [15:0] a0;
    logic stable;
    fw = -1; ew = -1; k = 0; stable = 1; c = 0; a0 = 0;
    @(negedge clk); start = 1; abort = sa;
    @(negedge clk); start = 0; abort = 0;
    chk("start_busy", busy, 1);
    while (!done && c < 2000) begin
      code_vld = 0; op_rdy = 0; abort = 0; code_opcode = 8'($urandom);
      if (code_req) begin
        if (fw < 0) begin fw = $urandom_range(fh, fl); a0 = code_addr; end
        if (code_addr !== a0) stable = 0;
        if (fw == 0) begin code_vld = 1; code_opcode = t_opc[code_addr[5:0]]; fw = -1; end else fw--;
      end
      if (op_vld) begin
        if (ew < 0) ew = $urandom_range(eh, el);
        if (op_code !== t_opc[pc[5:0]]) stable = 0;
        drive_op(int'(pc[5:0]));
        if (ew == 0) begin op_rdy = 1; ew = -1; k++; if (k == abort_n) abort = 1; end else ew--;
      end
      @(negedge clk); c++;
    end
    code_vld = 0; op_rdy = 0; abort = 0;
    chk("stable", stable, 1);
    chk("timeout", c < 2000, 1);
  endtask
  task automatic check_run(input string tag, input int abort_n);
    int st, h, n;
    longint mpc, gas;
    model(abort_n, st, mpc, gas, h, n);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_status"}, status, st);
    chk({tag, "_pc"}, pc, mpc);
    chk({tag, "_gas"}, gas_used, gas);
    chk({tag, "_height"}, height, h);
    chk({tag, "_cnt"}, instr_cnt, n);
  endtask
  task automatic linear_prog();
    clr_prog();
    for (int i = 0; i < 4; i++) begin t_push[i] = 1; t_gas[i] = 3; end
    code_size = 4; gas_limit = 100;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 0); chk("rst_gas", gas_used, 0); chk("rst_height", height, 0);
    chk("rst_cnt", instr_cnt, 0); chk("rst_status", status, 0); chk("rst_opcode", op_code, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_req", code_req, 0); chk("rst_opvld", op_vld, 0);
    rst = 0;
    linear_prog();
    run(0, 0, 0, 0, 0, 0, cyc);
    chk("linear_cycles", cyc, 9);
    chk("linear_status", status, 1); chk("linear_pc", pc, 4); chk("linear_gas", gas_used, 12);
    chk("linear_height", height, 4); chk("linear_cnt", instr_cnt, 4);
    run(3, 3, 2, 2, 0, 0, cyc);
    chk("wait_cycles", cyc, 4 * 7 + 1);
    check_run("wait", 0);
    clr_prog(); code_size = 4; gas_limit = 100;
    t_jmp[0] = 1; t_ok[0] = 1; t_dst[0] = 2; t_halt[2] = 1;
    run(0, 0, 0, 0, 0, 0, cyc);
    check_run("jump", 0);
    chk("jump_pc", pc, 2);
    t_dst[0] = 5;
    run(0, 1, 0, 1, 0, 0, cyc);
    check_run("badjump", 0);
    chk("badjump_status", status, 5);
    clr_prog(); code_size = 4; gas_limit = 10;
    for (int i = 0; i < 4; i++) t_gas[i] = 4;
    run(0, 0, 0, 0, 0, 0, cyc);
    chk("oog_status", status, 2); chk("oog_gas", gas_used, 10); chk("oog_cnt", instr_cnt, 2);
    clr_prog(); code_size = 4; gas_limit = 10; t_pop[0] = 1;
    run(0, 0, 0, 0, 0, 0, cyc);
    chk("under_status", status, 3); chk("under_height", height, 0);
    clr_prog(); code_size = 6; gas_limit = 10;
    for (int i = 0; i < 6; i++) t_push[i] = 1;
    run(0, 2, 0, 2, 0, 0, cyc);
    chk("over_status", status, 4); chk("over_height", height, 4); chk("over_cnt", instr_cnt, 4);
    clr_prog(); code_size = 16'hFFFF; gas_limit = 100;
    t_jmp[0] = 1; t_ok[0] = 1; t_dst[0] = 16'hFFFE; t_len[62] = 2;
    run(0, 0, 0, 0, 0, 0, cyc);
    check_run("carry", 0);
    chk("carry_pc", pc, 16'hFFFF);
    linear_prog();
    run(0, 1, 0, 1, 2, 0, cyc);
    check_run("abort", 2);
    chk("abort_status", status, 6);
    run(0, 0, 0, 0, 0, 1, cyc);
    check_run("start_abort", 0);
    linear_prog();
    code_vld = 1; op_rdy = 1; drive_op(0);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int j = 0; j < 50 && !(op_vld && instr_cnt == 2); j++) @(negedge clk);
    chk("pre_rst_cnt", instr_cnt, 2);
    op_rdy = 0; code_vld = 0; rst = 1;
    @(negedge clk); rst = 0;
    chk("mid_rst_pc", pc, 0); chk("mid_rst_gas", gas_used, 0); chk("mid_rst_height", height, 0);
    chk("mid_rst_cnt", instr_cnt, 0); chk("mid_rst_status", status, 0); chk("mid_rst_opcode", op_code, 0);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0); chk("mid_rst_opvld", op_vld, 0);
    for (int r = 0; r < 40; r++) begin
      int an;
      clr_prog();
      code_size = 16'($urandom_range(20, 1));
      gas_limit = $urandom_range(60, 5);
      for (int i = 0; i < 64; i++) begin
        t_pop[i] = $urandom_range(2, 0); t_push[i] = $urandom_range(2, 0);
        t_gas[i] = $urandom_range(5, 1); t_len[i] = $urandom_range(3, 1);
        t_jmp[i] = ($urandom_range(7, 0) == 0) ? 1 : 0; t_ok[i] = ($urandom_range(3, 0) != 0) ? 1 : 0;
        t_dst[i] = $urandom_range(int'(code_size) + 1, 0); t_halt[i] = ($urandom_range(15, 0) == 0) ? 1 : 0;
      end
      an = ($urandom_range(4, 0) == 0) ? $urandom_range(6, 1) : 0;
      run(0, 2, 0, 2, an, 0, cyc);
      check_run("rand", an);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
